// File: rtl/array_feed_scheduler_pkg.sv
// Shared types and default sizing for the array feed scheduler.
package array_feed_scheduler_pkg;

    localparam int unsigned DefaultW       = 32;
    localparam int unsigned DefaultD       = 8;
    localparam int unsigned DefaultTimeout = 1024;
    localparam int unsigned TileCountW     = 16;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StWaitFull,
        StDrain,
        StDone
    } state_e;

endpackage

// File: rtl/feed_rr_arbiter2.sv
// Two-requester round-robin grant selection; the pointer only moves on a completed tile.
module feed_rr_arbiter2 (
    input  logic clk,
    input  logic reset,
    input  logic valid0,
    input  logic valid1,
    input  logic advance,
    input  logic done_id,
    output logic any_valid,
    output logic grant
);

    logic rr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q <= 1'b0;
        end else if (advance) begin
            rr_q <= ~done_id;
        end
    end

    always_comb begin
        any_valid = valid0 | valid1;
        // With a single requester the pointer is irrelevant.
        if (valid0 && valid1) begin
            grant = rr_q;
        end else begin
            grant = valid1;
        end
    end

endmodule

// File: rtl/array_feed_scheduler.sv
// Loads one D-word tile from the granted requester into the master FIFO, then waits for the
// delivery array to fill and drain it before releasing the grant.
module array_feed_scheduler
    import array_feed_scheduler_pkg::*;
#(
    parameter int unsigned W       = DefaultW,
    parameter int unsigned D       = DefaultD,
    parameter int unsigned TIMEOUT = DefaultTimeout
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    input  logic [W-1:0]          req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [W-1:0]          req1_data,
    output logic                  req1_ready,
    output logic                  mst_we,
    output logic [W-1:0]          mst_data,
    input  logic                  master_full,
    input  logic                  master_empty,
    input  logic                  global_read_enable,
    output logic                  grant_id,
    output logic                  busy,
    output logic                  tile_done,
    output logic [TileCountW-1:0] tile_count,
    output logic                  err
);

    localparam int unsigned CntW = $clog2(D + 1);
    localparam int unsigned TmoW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] WordsPerTile = CntW'(D);
    localparam logic [CntW-1:0] LastWord     = CntW'(D - 1);
    localparam logic [TmoW-1:0] TmoLast      = TmoW'(TIMEOUT - 1);

    state_e                state_q, state_d;
    logic [CntW-1:0]       word_cnt_q, word_cnt_d;
    logic [TmoW-1:0]       tmo_q, tmo_d;
    logic                  grant_q, grant_d;
    logic [TileCountW-1:0] tile_count_q, tile_count_d;
    logic                  err_q, err_d;
    logic                  seen_re_q, seen_re_d;

    logic         arb_any;
    logic         arb_grant;
    logic         rr_advance;
    logic         load_ready;
    logic         gnt_valid;
    logic [W-1:0] gnt_data;
    logic         xfer;

    feed_rr_arbiter2 u_arb (
        .clk       (clk),
        .reset     (reset),
        .valid0    (req0_valid),
        .valid1    (req1_valid),
        .advance   (rr_advance),
        .done_id   (grant_q),
        .any_valid (arb_any),
        .grant     (arb_grant)
    );

    assign gnt_valid  = grant_q ? req1_valid : req0_valid;
    assign gnt_data   = grant_q ? req1_data : req0_data;
    assign load_ready = (state_q == StLoad) && (word_cnt_q < WordsPerTile);
    assign xfer       = load_ready & gnt_valid;

    assign req0_ready = load_ready & ~grant_q;
    assign req1_ready = load_ready & grant_q;
    assign mst_we     = xfer;
    assign mst_data   = (state_q == StLoad) ? gnt_data : '0;
    assign grant_id   = grant_q;
    assign busy       = (state_q != StIdle);
    assign tile_count = tile_count_q;
    assign err        = err_q;

    always_comb begin
        state_d      = state_q;
        word_cnt_d   = word_cnt_q;
        tmo_d        = tmo_q;
        grant_d      = grant_q;
        tile_count_d = tile_count_q;
        err_d        = err_q;
        seen_re_d    = seen_re_q;
        rr_advance   = 1'b0;
        tile_done    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (arb_any) begin
                    grant_d    = arb_grant;
                    word_cnt_d = '0;
                    state_d    = StLoad;
                end
            end
            StLoad: begin
                // A full FIFO before the tile is complete means someone else wrote into it.
                if (master_full) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else if (xfer) begin
                    word_cnt_d = word_cnt_q + 1'b1;
                    if (word_cnt_q == LastWord) begin
                        tmo_d   = '0;
                        state_d = StWaitFull;
                    end
                end
            end
            StWaitFull: begin
                if (master_full) begin
                    tmo_d     = '0;
                    seen_re_d = 1'b0;
                    state_d   = StDrain;
                end else if (tmo_q == TmoLast) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StDrain: begin
                if (global_read_enable) begin
                    seen_re_d = 1'b1;
                end
                // Empty only counts once the array has actually started reading this tile.
                if (master_empty && (seen_re_q || global_read_enable)) begin
                    state_d = StDone;
                end else if (tmo_q == TmoLast) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StDone: begin
                tile_done    = 1'b1;
                tile_count_d = tile_count_q + 1'b1;
                rr_advance   = 1'b1;
                state_d      = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            word_cnt_q   <= '0;
            tmo_q        <= '0;
            grant_q      <= 1'b0;
            tile_count_q <= '0;
            err_q        <= 1'b0;
            seen_re_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_cnt_q   <= word_cnt_d;
            tmo_q        <= tmo_d;
            grant_q      <= grant_d;
            tile_count_q <= tile_count_d;
            err_q        <= err_d;
            seen_re_q    <= seen_re_d;
        end
    end

endmodule

// File: tb/tb_array_feed_scheduler.sv
// Randomized bench: requester queues and a stub master FIFO drive the scheduler; a tile-level
// model (round-robin owner, word order, tile count) supplies the expectations.
module tb_array_feed_scheduler;

    localparam int unsigned W     = 32;
    localparam int unsigned D     = 8;
    localparam int          NEVER = 1 << 30;

    logic         clk = 1'b0;
    logic         reset;
    logic         req0_valid, req1_valid;
    logic [W-1:0] req0_data, req1_data;
    logic         master_full, master_empty, global_read_enable;

    logic         req0_ready, req1_ready, mst_we, grant_id, busy, tile_done, err;
    logic [W-1:0] mst_data;
    logic [15:0]  tile_count;

    logic         t_req0_ready, t_req1_ready, t_mst_we, t_grant_id, t_busy, t_tile_done, t_err;
    logic [W-1:0] t_mst_data;
    logic [15:0]  t_tile_count;

    always #5 clk = ~clk;

    array_feed_scheduler #(.W(W), .D(D), .TIMEOUT(1024)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .mst_we(mst_we), .mst_data(mst_data),
        .master_full(master_full), .master_empty(master_empty),
        .global_read_enable(global_read_enable),
        .grant_id(grant_id), .busy(busy), .tile_done(tile_done),
        .tile_count(tile_count), .err(err)
    );

    // Same stimulus, short timeout: only its timeout behaviour is examined.
    array_feed_scheduler #(.W(W), .D(D), .TIMEOUT(16)) dut_t (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(t_req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(t_req1_ready),
        .mst_we(t_mst_we), .mst_data(t_mst_data),
        .master_full(master_full), .master_empty(master_empty),
        .global_read_enable(global_read_enable),
        .grant_id(t_grant_id), .busy(t_busy), .tile_done(t_tile_done),
        .tile_count(t_tile_count), .err(t_err)
    );

    logic [W-1:0] q0[$], q1[$], wr_log[$], exp_q[$];
    logic [W-1:0] junk;
    int  cyc = 0;
    int  wr_cnt, full_at, full_thresh, full_delay, drain_start, drain_gap, last_wr_cyc;
    int  stall_after, stall_len, acc0, done_cnt, viol;
    bit  hold;
    int  total = 0;
    int  bad = 0;
    bit          model_rr;
    logic [15:0] model_tc;

    logic         s_r0, s_r1, s_we, s_grant, s_busy, s_done, s_err, s_full, s_terr, s_tbusy;
    logic [W-1:0] s_data;
    logic [15:0]  s_tc;

    // One clock: drive inputs at the falling edge, sample just after, let the rising edge act.
    task automatic step();
        bit stalled;
        stalled = (acc0 == stall_after) && (stall_len > 0);
        if (stalled) stall_len--;
        req0_valid = !hold && !stalled && (q0.size() > 0);
        req0_data  = req0_valid ? q0[0] : $urandom();
        req1_valid = !hold && (q1.size() > 0);
        req1_data  = req1_valid ? q1[0] : $urandom();
        master_full        = (cyc >= full_at) && (cyc < drain_start);
        global_read_enable = (cyc >= drain_start) && (cyc < drain_start + drain_gap);
        master_empty       = (wr_cnt == 0) || (cyc >= drain_start + drain_gap);
        #1;
        s_r0 = req0_ready;  s_r1 = req1_ready;  s_we = mst_we;  s_data = mst_data;
        s_grant = grant_id; s_busy = busy;      s_done = tile_done;
        s_err = err;        s_tc = tile_count;  s_full = master_full;
        s_terr = t_err;     s_tbusy = t_busy;
        if (s_r0 && req0_valid) begin junk = q0.pop_front(); acc0++; end
        if (s_r1 && req1_valid) junk = q1.pop_front();
        if ((s_r0 && s_grant) || (s_r1 && !s_grant)) viol++;
        if (s_we) begin
            wr_log.push_back(s_data);
            wr_cnt++;
            last_wr_cyc = cyc;
            if (wr_cnt == full_thresh) full_at = cyc + full_delay;
        end
        if (s_full && drain_start == NEVER) drain_start = cyc + 1;
        if (s_done) begin
            done_cnt++;
            wr_cnt = 0; full_at = NEVER; drain_start = NEVER;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic clear_stub();
        wr_cnt = 0; full_at = NEVER; drain_start = NEVER;
        full_thresh = D; full_delay = 2; drain_gap = 20;
        stall_after = -1; stall_len = 0; acc0 = 0;
        done_cnt = 0; viol = 0; wr_log.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1; hold = 1'b1;
        q0.delete(); q1.delete();
        clear_stub();
        step(); step();
        reset = 1'b0; hold = 1'b0;
        model_rr = 1'b0; model_tc = 16'h0000;
    endtask

    task automatic push8(input bit which);
        for (int i = 0; i < int'(D); i++) begin
            if (which) q1.push_back($urandom()); else q0.push_back($urandom());
        end
    endtask

    // Owner by round-robin over non-empty queues; its next D words are the tile.
    task automatic plan(output bit g);
        if (q0.size() > 0 && q1.size() > 0) g = model_rr;
        else g = (q1.size() > 0);
        exp_q.delete();
        for (int i = 0; i < int'(D); i++) exp_q.push_back(g ? q1[i] : q0[i]);
    endtask

    task automatic run_tile(input string tag, input bit exp_g);
        int n, miss;
        wr_log.delete(); done_cnt = 0; viol = 0; n = 0;
        while (done_cnt == 0 && n < 300) begin step(); n++; end
        total++;
        if (done_cnt !== 1) $display("FAIL %s tile_done: got %0d pulses want 1", tag, done_cnt);
        total++;
        if (s_grant !== exp_g) begin
            bad++; $display("FAIL %s grant_id: got %0d want %0d", tag, s_grant, exp_g);
        end
        if (done_cnt !== 1) bad++;
        total++;
        if (wr_log.size() != int'(D)) begin
            bad++; $display("FAIL %s write count: got %0d want %0d", tag, wr_log.size(), D);
        end else begin
            miss = 0;
            for (int i = 0; i < int'(D); i++) if (wr_log[i] !== exp_q[i]) miss++;
            total++;
            if (miss != 0) begin
                bad++; $display("FAIL %s data order: got %0d wrong words want 0", tag, miss);
            end
        end
        total++;
        if (viol != 0) begin
            bad++; $display("FAIL %s ready of non-owner: got %0d cycles want 0", tag, viol);
        end
        total++;
        if (s_err !== 1'b0) begin bad++; $display("FAIL %s err: got %0d want 0", tag, s_err); end
        model_rr = ~exp_g;
        model_tc = model_tc + 16'd1;
        hold = 1'b1; step(); hold = 1'b0;
        total++;
        if (s_tc !== model_tc) begin
            bad++; $display("FAIL %s tile_count: got %0h want %0h", tag, s_tc, model_tc);
        end
        total++;
        if (s_done !== 1'b0 || s_busy !== 1'b0) begin
            bad++; $display("FAIL %s after done: got done=%0d busy=%0d want 0 0", tag, s_done, s_busy);
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if ({s_r0, s_r1, s_we, s_busy, s_done, s_err, s_grant} !== 7'b0) begin
            bad++;
            $display("FAIL reset flags: got r0=%0d r1=%0d we=%0d busy=%0d done=%0d err=%0d gnt=%0d want all 0",
                     s_r0, s_r1, s_we, s_busy, s_done, s_err, s_grant);
        end
        total++;
        if (s_data !== '0) begin bad++; $display("FAIL reset mst_data: got %0h want 0", s_data); end
        total++;
        if (s_tc !== 16'h0) begin bad++; $display("FAIL reset tile_count: got %0h want 0", s_tc); end
    endtask

    task automatic test_basic();
        bit g;
        do_reset();
        push8(0); push8(1);
        plan(g); run_tile("basic_first", g);
        plan(g); run_tile("basic_second", g);
        total++;
        if (g !== 1'b1) begin bad++; $display("FAIL second owner: got %0d want 1", g); end
    endtask

    task automatic test_reset_in_drain();
        bit g;
        int n;
        push8(1);
        plan(g);
        done_cnt = 0; n = 0;
        while (!(drain_start != NEVER && cyc > drain_start + 3) && n < 200) begin step(); n++; end
        total++;
        if (!s_busy || done_cnt != 0) begin
            bad++; $display("FAIL drain reach: got busy=%0d done=%0d want 1 0", s_busy, done_cnt);
        end
        reset = 1'b1; step(); reset = 1'b0;
        hold = 1'b1; step();
        total++;
        if ({s_r0, s_r1, s_we, s_busy, s_done, s_err, s_grant} !== 7'b0) begin
            bad++;
            $display("FAIL drain reset flags: got we=%0d busy=%0d done=%0d err=%0d gnt=%0d want 0",
                     s_we, s_busy, s_done, s_err, s_grant);
        end
        total++;
        if (s_tc !== 16'h0 || s_data !== '0) begin
            bad++; $display("FAIL drain reset count/data: got %0h/%0h want 0/0", s_tc, s_data);
        end
        for (int i = 0; i < 30; i++) step();
        total++;
        if (done_cnt != 0) begin bad++; $display("FAIL drain reset tile_done: got %0d want 0", done_cnt); end
        hold = 1'b0;
    endtask

    task automatic test_stall();
        bit g;
        do_reset();
        push8(0); push8(1);
        stall_after = 4; stall_len = 3;
        plan(g);
        run_tile("stall", g);
    endtask

    task automatic test_early_full();
        int n;
        do_reset();
        push8(0); push8(1);
        full_thresh = 5;
        n = 0;
        while (s_err !== 1'b1 && n < 100) begin step(); n++; end
        total++;
        if (s_err !== 1'b1) begin bad++; $display("FAIL early_full err: got %0d want 1", s_err); end
        total++;
        if (s_busy !== 1'b0) begin bad++; $display("FAIL early_full busy: got %0d want 0", s_busy); end
        total++;
        if (wr_log.size() != 7) begin
            bad++; $display("FAIL early_full writes: got %0d want 7", wr_log.size());
        end
        total++;
        if (s_tc !== 16'h0) begin bad++; $display("FAIL early_full tile_count: got %0h want 0", s_tc); end
        n = 0;
        while (s_busy !== 1'b1 && n < 20) begin step(); n++; end
        total++;
        if (s_busy !== 1'b1 || s_grant !== 1'b0) begin
            bad++; $display("FAIL early_full regrant: got busy=%0d gnt=%0d want 1 0", s_busy, s_grant);
        end
        total++;
        if (s_err !== 1'b1) begin bad++; $display("FAIL early_full sticky err: got %0d want 1", s_err); end
    endtask

    task automatic test_timeout();
        int n, err_cyc;
        do_reset();
        push8(0);
        full_thresh = NEVER;
        n = 0;
        while (s_terr !== 1'b1 && n < 80) begin step(); n++; end
        err_cyc = cyc - 1;
        total++;
        if (s_terr !== 1'b1 || err_cyc - last_wr_cyc != 17) begin
            bad++;
            $display("FAIL timeout delay: got err=%0d after %0d cycles want 1 after 17",
                     s_terr, err_cyc - last_wr_cyc);
        end
        total++;
        if (s_tbusy !== 1'b0) begin bad++; $display("FAIL timeout busy: got %0d want 0", s_tbusy); end
        step();
        total++;
        if (s_tbusy !== 1'b0 || s_terr !== 1'b1) begin
            bad++; $display("FAIL timeout after: got busy=%0d err=%0d want 0 1", s_tbusy, s_terr);
        end
        total++;
        if (s_busy !== 1'b1 || s_err !== 1'b0) begin
            bad++; $display("FAIL long timeout instance: got busy=%0d err=%0d want 1 0", s_busy, s_err);
        end
    endtask

    task automatic test_wrap();
        bit g;
        do_reset();
        push8($urandom_range(0, 1) == 1);
        hold = 1'b1;
        force dut.tile_count_q = 16'hFFFF;
        step();
        release dut.tile_count_q;
        step();
        hold = 1'b0;
        total++;
        if (s_tc !== 16'hFFFF) begin bad++; $display("FAIL preload: got %0h want ffff", s_tc); end
        model_tc = 16'hFFFF;
        plan(g);
        run_tile("wrap", g);
    endtask

    task automatic test_multi_tile();
        bit g;
        int pick;
        do_reset();
        for (int t = 0; t < 6; t++) begin
            pick = $urandom_range(0, 2);
            full_delay = $urandom_range(1, 3);
            drain_gap = $urandom_range(1, 10);
            if (pick != 1) push8(0);
            if (pick != 0) push8(1);
            plan(g);
            run_tile("multi", g);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reset_in_drain();
        test_stall();
        test_early_full();
        test_timeout();
        test_wrap();
        test_multi_tile();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
